// File: rtl/dir_button_conditioner.sv
// Four raw push-buttons in, clean one-cycle direction pulses out.
// Presses landing inside one gather window merge into a single (possibly diagonal) move.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no button held, waiting for the first debounced press
// GATHER   | collecting presses for COMBINE_CYC cycles into acc
// EMIT     | one cycle, direction outputs carry the resolved acc
// WAIT_REL | move issued, waiting for every button to be released
module dir_button_conditioner #(
    parameter int DEBOUNCE_CYC   = 500000,
    parameter int COMBINE_CYC    = 2500000,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_left,
    input  logic btn_right,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic move_req
);

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int TW = (COMBINE_CYC > 1) ? $clog2(COMBINE_CYC) : 1;
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(COMBINE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GATHER   = 2'd1,
        S_EMIT     = 2'd2,
        S_WAIT_REL = 2'd3
    } state_t;

    // bit order everywhere: [3]=up [2]=down [1]=left [0]=right
    logic [3:0] raw_pressed;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] press;

    // Polarity is folded in ahead of the synchroniser so the reset value 0
    // means "released" and a button held through reset debounces as a fresh press.
    assign raw_pressed = {btn_up, btn_down, btn_left, btn_right} ^ {4{BTN_ACTIVE_LOW}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_pressed;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_db
        logic [DW-1:0] db_cnt;
        logic          stable;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                db_cnt <= '0;
                stable <= 1'b0;
            end else if (sync2[i] == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt <= '0;
                stable <= sync2[i];
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end

        assign press[i] = stable;
    end

    function automatic logic [3:0] resolve(input logic [3:0] a);
        logic [3:0] r;
        r = a;
        if (a[3] && a[2]) r[3:2] = 2'b00;
        if (a[1] && a[0]) r[1:0] = 2'b00;
        return r;
    endfunction

    state_t        state, state_nxt;
    logic [3:0]    acc, acc_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [3:0]    dir_q, dir_nxt;
    logic          move_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            acc    <= '0;
            timer  <= '0;
            dir_q  <= '0;
            move_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            timer  <= timer_nxt;
            dir_q  <= dir_nxt;
            move_q <= |dir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        timer_nxt = timer;
        dir_nxt   = '0;
        case (state)
            S_IDLE: begin
                if (|press) begin
                    state_nxt = S_GATHER;
                    acc_nxt   = press;
                    timer_nxt = TMR_LOAD;
                end
            end
            S_GATHER: begin
                acc_nxt = acc | press;
                if (timer == '0) begin
                    state_nxt = S_EMIT;
                    dir_nxt   = resolve(acc_nxt);
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            S_EMIT: begin
                state_nxt = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (press == '0) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign {up, down, left, right} = dir_q;
    assign move_req                = move_q;

endmodule
